// File: rtl/seg_argmax_head.sv
// Per-pixel argmax head: pipelined compare tree over UNITS signed fixed-point
// channels, then conversion of the winning score to a rounded, saturated uint.
module seg_argmax_head #(
  parameter int HEIGHT    = 4,
  parameter int WIDTH     = 4,
  parameter int W_HEIGHT  = 8,
  parameter int W_WIDTH   = 8,
  parameter int UNITS     = 12,
  parameter int INT_BITW  = 5,
  parameter int FRAC_BITW = 8,
  parameter int UINT_BITW = 8,
  parameter int FCNT_BITW = 16,
  localparam int FIXED_BITW = INT_BITW + FRAC_BITW,
  localparam int V_BITW     = $clog2(W_HEIGHT),
  localparam int H_BITW     = $clog2(W_WIDTH),
  localparam int LBL_BITW   = ($clog2(UNITS) < 1) ? 1 : $clog2(UNITS)
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          in_enable,
  input  logic [FIXED_BITW*UNITS-1:0]   in_feat,
  input  logic [V_BITW-1:0]             in_vcnt,
  input  logic [H_BITW-1:0]             in_hcnt,
  output logic                          out_enable,
  output logic [LBL_BITW-1:0]           out_label,
  output logic [UINT_BITW-1:0]          out_conf,
  output logic [V_BITW-1:0]             out_vcnt,
  output logic [H_BITW-1:0]             out_hcnt,
  output logic                          out_frame_end,
  output logic [FCNT_BITW-1:0]          out_frame_cnt
);

  // Stream semantics: in_enable/out_enable qualify the pixel on the same
  // cycle; there is no ready, every cycle shifts the whole pipeline.
  localparam int DEPTH = $clog2(UNITS);
  localparam int HALF  = (UNITS + 1) / 2;
  localparam int NP    = 2 * HALF;
  localparam int SHIFT = FRAC_BITW - UINT_BITW;
  localparam int RW    = FIXED_BITW + 1;

  typedef logic signed [FIXED_BITW-1:0] val_t;
  typedef logic [LBL_BITW-1:0]          idx_t;

  function automatic int level_nodes(input int k);
    return (UNITS + (1 << k) - 1) >> k;
  endfunction

  val_t src_v  [0:DEPTH-1][0:NP-1];
  idx_t src_i  [0:DEPTH-1][0:NP-1];
  val_t tree_v [1:DEPTH][0:NP-1];
  idx_t tree_i [1:DEPTH][0:NP-1];

  logic              en_pipe   [0:DEPTH-1];
  logic [V_BITW-1:0] vcnt_pipe [0:DEPTH-1];
  logic [H_BITW-1:0] hcnt_pipe [0:DEPTH-1];

  // Level 0 is the raw input vector (unit 0 in the leftmost field).
  always_comb begin
    for (int j = 0; j < NP; j++) begin
      src_v[0][j] = '0;
      src_i[0][j] = '0;
    end
    for (int j = 0; j < UNITS; j++) begin
      src_v[0][j] = val_t'(in_feat[FIXED_BITW*(UNITS-j)-1 -: FIXED_BITW]);
      src_i[0][j] = idx_t'(j);
    end
    for (int k = 1; k < DEPTH; k++) begin
      for (int j = 0; j < NP; j++) begin
        src_v[k][j] = tree_v[k][j];
        src_i[k][j] = tree_i[k][j];
      end
    end
  end

  // Left operand wins on >= so the lowest index among equal maxima survives.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        for (int j = 0; j < NP; j++) begin
          tree_v[k][j] <= '0;
          tree_i[k][j] <= '0;
        end
      end
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        for (int j = 0; j < HALF; j++) begin
          if (2*j + 1 < level_nodes(k-1)) begin
            if (src_v[k-1][2*j] >= src_v[k-1][2*j+1]) begin
              tree_v[k][j] <= src_v[k-1][2*j];
              tree_i[k][j] <= src_i[k-1][2*j];
            end else begin
              tree_v[k][j] <= src_v[k-1][2*j+1];
              tree_i[k][j] <= src_i[k-1][2*j+1];
            end
          end else if (2*j < level_nodes(k-1)) begin
            tree_v[k][j] <= src_v[k-1][2*j];
            tree_i[k][j] <= src_i[k-1][2*j];
          end else begin
            tree_v[k][j] <= '0;
            tree_i[k][j] <= '0;
          end
        end
        for (int j = HALF; j < NP; j++) begin
          tree_v[k][j] <= '0;
          tree_i[k][j] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        en_pipe[i]   <= 1'b0;
        vcnt_pipe[i] <= '0;
        hcnt_pipe[i] <= '0;
      end
    end else begin
      en_pipe[0]   <= in_enable;
      vcnt_pipe[0] <= in_vcnt;
      hcnt_pipe[0] <= in_hcnt;
      for (int i = 1; i < DEPTH; i++) begin
        en_pipe[i]   <= en_pipe[i-1];
        vcnt_pipe[i] <= vcnt_pipe[i-1];
        hcnt_pipe[i] <= hcnt_pipe[i-1];
      end
    end
  end

  val_t                 max_v;
  logic [RW-1:0]        mag;
  logic [RW-1:0]        rnd;
  logic [UINT_BITW-1:0] conf_next;
  logic                 frame_end_next;

  assign max_v = tree_v[DEPTH][0];
  assign mag   = {1'b0, max_v};

  // Round half up by adding one at the first dropped bit position.
  generate
    if (SHIFT == 0) begin : g_no_round
      assign rnd = mag;
    end else begin : g_round
      assign rnd = ((mag >> (SHIFT - 1)) + RW'(1)) >> 1;
    end
  endgenerate

  always_comb begin
    conf_next = rnd[UINT_BITW-1:0];
    if (max_v[FIXED_BITW-1]) begin
      conf_next = '0;
    end else if (rnd > RW'((1 << UINT_BITW) - 1)) begin
      conf_next = '1;
    end
  end

  assign frame_end_next = en_pipe[DEPTH-1]
                        && (vcnt_pipe[DEPTH-1] == V_BITW'(HEIGHT - 1))
                        && (hcnt_pipe[DEPTH-1] == H_BITW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (rst) begin
      out_enable    <= 1'b0;
      out_label     <= '0;
      out_conf      <= '0;
      out_vcnt      <= '0;
      out_hcnt      <= '0;
      out_frame_end <= 1'b0;
      out_frame_cnt <= '0;
    end else begin
      out_enable    <= en_pipe[DEPTH-1];
      out_label     <= tree_i[DEPTH][0];
      out_conf      <= conf_next;
      out_vcnt      <= vcnt_pipe[DEPTH-1];
      out_hcnt      <= hcnt_pipe[DEPTH-1];
      out_frame_end <= frame_end_next;
      if (out_frame_end) begin
        out_frame_cnt <= out_frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_argmax_head.sv
// Bench for seg_argmax_head: two instances (8-bit and 6-bit confidence) share
// one input stream; expected results come from a per-pixel reference model.
module tb_seg_argmax_head;

  localparam int U   = 12;
  localparam int FB  = 13;
  localparam int FW  = FB * U;
  localparam int LAT = 5;

  logic          clock;
  logic          rst;
  logic          in_enable;
  logic [FW-1:0] in_feat;
  logic [2:0]    in_vcnt;
  logic [2:0]    in_hcnt;

  logic        out_enable_a, out_frame_end_a;
  logic [3:0]  out_label_a;
  logic [7:0]  out_conf_a;
  logic [2:0]  out_vcnt_a, out_hcnt_a;
  logic [15:0] out_frame_cnt_a;
  logic        out_enable_b, out_frame_end_b;
  logic [3:0]  out_label_b;
  logic [5:0]  out_conf_b;
  logic [2:0]  out_vcnt_b, out_hcnt_b;
  logic [15:0] out_frame_cnt_b;

  seg_argmax_head #(.HEIGHT(4), .WIDTH(4), .W_HEIGHT(8), .W_WIDTH(8), .UNITS(U),
                    .INT_BITW(5), .FRAC_BITW(8), .UINT_BITW(8), .FCNT_BITW(16)) dut_a (
    .clock(clock), .rst(rst), .in_enable(in_enable), .in_feat(in_feat),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_enable(out_enable_a),
    .out_label(out_label_a), .out_conf(out_conf_a), .out_vcnt(out_vcnt_a),
    .out_hcnt(out_hcnt_a), .out_frame_end(out_frame_end_a), .out_frame_cnt(out_frame_cnt_a));

  seg_argmax_head #(.HEIGHT(4), .WIDTH(4), .W_HEIGHT(8), .W_WIDTH(8), .UNITS(U),
                    .INT_BITW(5), .FRAC_BITW(8), .UINT_BITW(6), .FCNT_BITW(16)) dut_b (
    .clock(clock), .rst(rst), .in_enable(in_enable), .in_feat(in_feat),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_enable(out_enable_b),
    .out_label(out_label_b), .out_conf(out_conf_b), .out_vcnt(out_vcnt_b),
    .out_hcnt(out_hcnt_b), .out_frame_end(out_frame_end_b), .out_frame_cnt(out_frame_cnt_b));

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       en;
    logic [3:0] label;
    logic [7:0] conf_a;
    logic [5:0] conf_b;
    logic [2:0] v;
    logic [2:0] h;
    logic       fe;
  } exp_t;

  typedef struct {
    logic [FW-1:0] feat;
    int            label;
    int            conf_a;
    int            conf_b;
  } vec_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   model_fcnt = 0;
  int   fe_seen = 0;

  // Reference model
  function automatic int feat_at(input logic [FW-1:0] f, input int u);
    logic signed [FB-1:0] x;
    x = f[FB*(U-u)-1 -: FB];
    return int'(x);
  endfunction

  function automatic int ref_label(input logic [FW-1:0] f);
    int best = 0;
    for (int u = 1; u < U; u++) if (feat_at(f, u) > feat_at(f, best)) best = u;
    return best;
  endfunction

  function automatic int ref_conf(input int m, input int ubits);
    int s, r;
    s = 8 - ubits;
    if (m < 0) return 0;
    r = (s == 0) ? m : (m + (1 << (s - 1))) / (1 << s);
    if (r > (1 << ubits) - 1) return (1 << ubits) - 1;
    return r;
  endfunction

  function automatic logic [FW-1:0] mk_feat(input logic [FB-1:0] rest, input int u1,
                                            input logic [FB-1:0] v1, input int u2,
                                            input logic [FB-1:0] v2);
    logic [FW-1:0] f;
    f = {U{rest}};
    if (u1 >= 0) f[FB*(U-u1)-1 -: FB] = v1;
    if (u2 >= 0) f[FB*(U-u2)-1 -: FB] = v2;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Driver tasks
  task automatic drive(input logic en, input int v, input int h, input logic [FW-1:0] f,
                       input int lbl, input int ca, input int cb);
    exp_t e;
    in_enable = en;
    in_vcnt   = 3'(v);
    in_hcnt   = 3'(h);
    in_feat   = f;
    e.en     = en;
    e.label  = 4'(lbl);
    e.conf_a = 8'(ca);
    e.conf_b = 6'(cb);
    e.v      = 3'(v);
    e.h      = 3'(h);
    e.fe     = en && (v == 3) && (h == 3);
    exp_q.push_back(e);
  endtask

  task automatic drive_model(input logic en, input int v, input int h, input logic [FW-1:0] f);
    int lbl, mx;
    lbl = ref_label(f);
    mx  = feat_at(f, lbl);
    drive(en, v, h, f, lbl, ref_conf(mx, 8), ref_conf(mx, 6));
  endtask

  task automatic drive_idle();
    drive(1'b0, 0, 0, '0, 0, 0, 0);
  endtask

  function automatic logic [FW-1:0] rand_feat();
    logic [FW-1:0] f;
    logic [FB-1:0] x;
    for (int u = 0; u < U; u++) begin
      case ($urandom_range(0, 3))
        0:       x = FB'($urandom_range(0, 3));
        1:       x = FB'(13'h1F00 + $urandom_range(0, 255));
        default: x = FB'($urandom);
      endcase
      f[FB*(U-u)-1 -: FB] = x;
    end
    return f;
  endfunction

  // Scoreboard: one sample per cycle on the falling edge
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (out_frame_end_a) fe_seen++;
    if (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      check("enable_a", 32'(out_enable_a), 32'(e.en));
      check("enable_b", 32'(out_enable_b), 32'(e.en));
      check("frame_end_a", 32'(out_frame_end_a), 32'(e.fe));
      check("frame_end_b", 32'(out_frame_end_b), 32'(e.fe));
      if (e.en) begin
        check("label_a", 32'(out_label_a), 32'(e.label));
        check("label_b", 32'(out_label_b), 32'(e.label));
        check("conf_a", 32'(out_conf_a), 32'(e.conf_a));
        check("conf_b", 32'(out_conf_b), 32'(e.conf_b));
        check("vcnt_a", 32'(out_vcnt_a), 32'(e.v));
        check("hcnt_a", 32'(out_hcnt_a), 32'(e.h));
        check("vcnt_b", 32'(out_vcnt_b), 32'(e.v));
        check("hcnt_b", 32'(out_hcnt_b), 32'(e.h));
      end
      check("frame_cnt_a", 32'(out_frame_cnt_a), 32'(model_fcnt));
      check("frame_cnt_b", 32'(out_frame_cnt_b), 32'(model_fcnt));
      if (e.fe) model_fcnt++;
    end
  endtask

  task automatic apply_reset();
    exp_t idle;
    rst = 1'b1;
    in_enable = 1'b0;
    in_feat = '0;
    in_vcnt = '0;
    in_hcnt = '0;
    @(negedge clock);
    check("rst_enable_a", 32'(out_enable_a), 0);
    check("rst_label_a", 32'(out_label_a), 0);
    check("rst_conf_a", 32'(out_conf_a), 0);
    check("rst_vcnt_a", 32'(out_vcnt_a), 0);
    check("rst_hcnt_a", 32'(out_hcnt_a), 0);
    check("rst_frame_end_a", 32'(out_frame_end_a), 0);
    check("rst_frame_cnt_a", 32'(out_frame_cnt_a), 0);
    check("rst_enable_b", 32'(out_enable_b), 0);
    check("rst_conf_b", 32'(out_conf_b), 0);
    check("rst_frame_cnt_b", 32'(out_frame_cnt_b), 0);
    rst = 1'b0;
    exp_q.delete();
    model_fcnt = 0;
    idle = '0;
    repeat (LAT - 1) exp_q.push_back(idle);
    drive_idle();
  endtask

  task automatic flush();
    repeat (LAT + 1) begin
      tick();
      drive_idle();
    end
  endtask

  task automatic stream_frame(input int n_pixels);
    int k = 0;
    for (int v = 0; v < 8; v++) begin
      for (int h = 0; h < 8; h++) begin
        if (k < n_pixels) begin
          tick();
          drive_model((v < 4) && (h < 4), v, h, rand_feat());
        end
        k++;
      end
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{mk_feat(13'h1F00, 7, 13'h0280, -1, '0), 7, 255, 63};
    tbl[1] = '{mk_feat(13'h0000, 3, 13'h0040, 9, 13'h0040), 3, 64, 16};
    tbl[2] = '{mk_feat(13'h1F00, 11, 13'h1FFF, -1, '0), 11, 0, 0};
    tbl[3] = '{mk_feat(13'h0000, 0, 13'h0006, -1, '0), 0, 6, 2};
    tbl[4] = '{mk_feat(13'h0000, 0, 13'h0005, -1, '0), 0, 5, 1};
    tbl[5] = '{mk_feat(13'h1F00, -1, '0, -1, '0), 0, 0, 0};
    tbl[6] = '{mk_feat(13'h0000, 11, 13'h00FF, -1, '0), 11, 255, 63};
    tbl[7] = '{mk_feat(13'h0001, 5, 13'h0082, -1, '0), 5, 130, 33};

    rst = 1'b1;
    in_enable = 1'b0;
    in_feat = '0;
    in_vcnt = '0;
    in_hcnt = '0;
    repeat (3) @(posedge clock);
    apply_reset();

    // Table vectors, streamed back to back
    for (int i = 0; i < 8; i++) begin
      tick();
      drive(1'b1, 5, 5, tbl[i].feat, tbl[i].label, tbl[i].conf_a, tbl[i].conf_b);
    end
    flush();

    // One full frame with blanking: a single end-of-frame pulse
    apply_reset();
    fe_seen = 0;
    stream_frame(64);
    flush();
    check("frame_end_pulses", 32'(fe_seen), 1);
    check("frame_cnt_after_frame", 32'(out_frame_cnt_a), 1);

    // Reset mid-frame flushes in-flight pixels; the next frame counts as the first
    apply_reset();
    stream_frame(20);
    tick();
    apply_reset();
    fe_seen = 0;
    stream_frame(64);
    flush();
    check("frame_end_pulses_after_rst", 32'(fe_seen), 1);
    check("frame_cnt_after_rst", 32'(out_frame_cnt_a), 1);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      tick();
      drive_model(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
                  rand_feat());
    end
    flush();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
